// File: rtl/fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// fnd_scan_driver
//
// Drives a multiplexed 4-digit 7-segment display from the 3-bit scan position
// produced by the FND digit-position counter. Odd positions are "on" slots
// for digit p[2:1]. Even positions are dead-time slots with everything dark.
//
// Display data is double-buffered. i_valueValid loads the pending buffer at
// any time. The visible buffer is updated only on the 7 -> 0 position wrap
// (the frame commit), so a digit never changes in the middle of a scan. The
// commit always lands in the dead-time slot of position 0.
//
// A blink phase toggles every BLINK_FRAMES commits. While the phase is 1,
// digits selected by i_blinkMask are blanked. Their common is still driven.
//
// Optional build macro:
//   FND_HEX_EN - decode nibbles 10..15 as A,b,C,d,E,F (otherwise blank)
//
// Parameters:
//   BLINK_FRAMES    frames per blink half-period (>= 1), default 125
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous active-high reset
//   i_digitPosition scan position 0..7
//   i_value         four BCD nibbles, [3:0] = digit 0 (rightmost)
//   i_valueValid    one-cycle strobe loading i_value into the pending buffer
//   i_dotMask       per-digit decimal point enable (live)
//   i_blinkMask     per-digit blink enable (live)
//   o_fndCom        active-low digit commons, bit n = digit n
//   o_fndFont       active-low segments {dp,g,f,e,d,c,b,a}
//   o_frameStart    one-cycle pulse on each frame commit
// -----------------------------------------------------------------------------
module fnd_scan_driver #(
  parameter int BLINK_FRAMES = 125
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_digitPosition,
  input  logic [15:0] i_value,
  input  logic        i_valueValid,
  input  logic [3:0]  i_dotMask,
  input  logic [3:0]  i_blinkMask,
  output logic [3:0]  o_fndCom,
  output logic [7:0]  o_fndFont,
  output logic        o_frameStart
);

  localparam int FCW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(BLINK_FRAMES - 1);

  // Active-low 7-segment font, {dp,g,f,e,d,c,b,a}; dp is left off here.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] f;
    case (nib)
      4'd0:    f = 8'hC0;
      4'd1:    f = 8'hF9;
      4'd2:    f = 8'hA4;
      4'd3:    f = 8'hB0;
      4'd4:    f = 8'h99;
      4'd5:    f = 8'h92;
      4'd6:    f = 8'h82;
      4'd7:    f = 8'hF8;
      4'd8:    f = 8'h80;
      4'd9:    f = 8'h90;
`ifdef FND_HEX_EN
      4'd10:   f = 8'h88;
      4'd11:   f = 8'h83;
      4'd12:   f = 8'hC6;
      4'd13:   f = 8'hA1;
      4'd14:   f = 8'h86;
      4'd15:   f = 8'h8E;
`endif
      default: f = 8'hFF;
    endcase
    return f;
  endfunction

  logic [15:0]    r_pending;
  logic [15:0]    r_display;
  logic [2:0]     r_prevPos;
  logic [FCW-1:0] r_frameCnt;
  logic           r_blinkPhase;
  logic [3:0]     r_fndCom;
  logic [7:0]     r_fndFont;
  logic           r_frameStart;

  logic           w_commit;
  logic [1:0]     w_digit;
  logic [3:0]     w_nibble;
  logic [7:0]     w_font;

  // Slot decode for the position being sampled this cycle.
  always_comb begin
    w_commit = (r_prevPos == 3'd7) && (i_digitPosition == 3'd0);
    w_digit  = i_digitPosition[2:1];
    w_nibble = r_display[{w_digit, 2'b00} +: 4];
    w_font   = seg_decode(w_nibble);
    if (i_dotMask[w_digit])
      w_font[7] = 1'b0;
    // Blanking overrides the dot as well.
    if (r_blinkPhase && i_blinkMask[w_digit])
      w_font = 8'hFF;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending    <= '0;
      r_display    <= '0;
      r_prevPos    <= '0;
      r_frameCnt   <= '0;
      r_blinkPhase <= 1'b0;
      r_fndCom     <= 4'hF;
      r_fndFont    <= 8'hFF;
      r_frameStart <= 1'b0;
    end else begin
      r_prevPos    <= i_digitPosition;
      r_frameStart <= w_commit;

      // A strobe coinciding with a commit lands in pending only; display
      // takes the previous pending value.
      if (i_valueValid)
        r_pending <= i_value;

      if (w_commit) begin
        r_display <= r_pending;
        if (r_frameCnt == LAST_FRAME) begin
          r_frameCnt   <= '0;
          r_blinkPhase <= ~r_blinkPhase;
        end else begin
          r_frameCnt <= r_frameCnt + 1'b1;
        end
      end

      if (!i_digitPosition[0]) begin
        r_fndCom  <= 4'hF;
        r_fndFont <= 8'hFF;
      end else begin
        r_fndCom  <= ~(4'b0001 << w_digit);
        r_fndFont <= w_font;
      end
    end
  end

  assign o_fndCom     = r_fndCom;
  assign o_fndFont    = r_fndFont;
  assign o_frameStart = r_frameStart;

endmodule
